fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Control engine that drives the radix-2 DIT butterfly unit through a complete in-place N-point FFT, N = 2^N_LOG2. For every butterfly it issues read addresses for the A/B operand pair and the twiddle ROM index. It then issues the matching write-back addresses once the butterfly result emerges. Operands ping-pong between two dual-port sample banks, one bank per stage direction. The block sits between the spectrum analyzer's acquisition/bit-reverse loader and the magnitude stage.

## Interface
Parameters:
- N_LOG2, 10: log2 of FFT length; legal range 2..12.
- PIPE_LAT, 2: cycles from read issue to butterfly output valid. Made up of 1 cycle RAM/ROM read and 1 cycle butterfly multiplier/A-pipe.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a transform; sampled only in IDLE.
- busy  out  1  high while a transform is in progress.
- done  out  1  one-cycle pulse after the final write of the final stage.
- rd_en  out  1  read strobe to the source bank, both ports.
- rd_addr_a  out  N_LOG2  A operand address.
- rd_addr_b  out  N_LOG2  B operand address.
- rd_bank  out  1  source bank select.
- tw_addr  out  N_LOG2-1  twiddle ROM index. The ROM holds -W_N^k for k = 0..N/2-1.
- wr_en  out  1  write strobe to the destination bank, both ports.
- wr_addr_a  out  N_LOG2  destination address for butterfly output A.
- wr_addr_b  out  N_LOG2  destination address for butterfly output B.
- wr_bank  out  1  destination bank select; always equals the inverse of rd_bank for that stage.
- result_bank  out  1  bank holding the finished spectrum, equal to N_LOG2 mod 2. Valid when done pulses and held until the next start.
- hold  in  1  issue stall; present only with FFT_SEQ_HOLD_EN.

## Operation
- FSM states:
  - IDLE: wait for start.
  - RUN: issue one butterfly per cycle.
  - DRAIN: wait for in-flight butterflies of the current stage.
  - FINISH: pulse done.
- Transitions:
  - IDLE→RUN on start.
  - RUN→DRAIN after issuing k = N/2-1.
  - DRAIN→RUN after PIPE_LAT cycles if stage < N_LOG2-1; the stage counter increments and rd_bank toggles.
  - DRAIN→FINISH after the last stage.
  - FINISH→IDLE unconditionally.
- Address rules, for stage s and counter k in 0..N/2-1, span = 2^s:
  - a = ((k >> s) << (s+1)) | (k & (span-1)).
  - b = a + span.
  - tw = (k & (span-1)) << (N_LOG2-1-s).
- Stage 0 reads bank 0. rd_bank = s mod 2.
- Write side: a PIPE_LAT-deep delay line carries {valid, addr_a, addr_b, bank}. wr_en equals the delayed valid.
- Within a stage every address is read and written once. DRAIN guarantees stage s+1 never reads before stage s writes land.
- start in any state other than IDLE is ignored.
- rst mid-transform:
  - Next cycle: state IDLE; the delay line valid bits clear, so wr_en = 0 and in-flight results are discarded.
  - busy = 0 and done = 0.
- Reset values:
  - busy, done, rd_en and wr_en = 0.
  - All addresses = 0.
  - rd_bank, wr_bank and result_bank = 0.

## Timing
- start sampled high in cycle 0.
- Cycle 1: busy = 1, rd_en = 1, first addresses presented.
- Addresses read in cycle t are written in cycle t+PIPE_LAT with wr_en = 1.
- Per stage: N/2 issue cycles + PIPE_LAT drain cycles.
- Total: busy high for N_LOG2·(N/2+PIPE_LAT) cycles.
- done pulses in the cycle after busy falls.
- Back-to-back runs: a start in the cycle after done begins a new transform.

## Configuration
- FFT_SEQ_HOLD_EN defined:
  - The hold port exists.
  - While hold = 1 in RUN: rd_en = 0 and the k counter freezes.
  - The delay line keeps shifting (the butterfly has no enable), so in-flight writes still complete.
  - DRAIN length counts only from the last real issue.
- FFT_SEQ_HOLD_EN undefined: no hold port; issue is unconditional.

## Structure
- Package fft_pkg holds:
  - N_LOG2 and PIPE_LAT defaults.
  - FSM state enum.
  - The pipeline-entry struct {valid, addr_a, addr_b, bank}.
- Sub-module fft_addr_gen computes a, b and tw combinationally from (s, k), so address rules can be unit-tested in isolation.

## Test plan
- N_LOG2 = 3, start: stage 0 issues (a,b,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0) from bank 0. Stage 1 issues (0,2,0),(1,3,2),(4,6,0),(5,7,2) from bank 1. Stage 2 issues (0,4,0),(1,5,1),(2,6,2),(3,7,3) from bank 0. busy high 18 cycles, done 1 cycle, result_bank = 1.
- Write alignment: each wr_addr pair equals the rd_addr pair from exactly 2 cycles earlier. No write overlaps the next stage's first read.
- Golden model: RAM and ROM models plus the butterfly run an 8-point impulse at index 0. Every output bin equals the impulse amplitude (no scaling in the datapath).
- start asserted during RUN: no effect, and total cycle count is unchanged.
- rst asserted at stage 1, k = 2: next cycle busy = 0 and wr_en = 0. No further writes occur. A later start performs a full clean 18-cycle run.
- FFT_SEQ_HOLD_EN, hold high 3 cycles at stage 0 k = 2: rd_en low for 3 cycles and pending writes still land. Total busy = 21 cycles with an identical address sequence.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT stage sequencer.
package fft_pkg;

  localparam int N_LOG2_DEF   = 10;
  localparam int PIPE_LAT_DEF = 2;
  localparam int N_LOG2_MAX   = 12;
  localparam int STG_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } seq_state_e;

  // Sized for the largest legal transform; narrower builds use the low bits.
  typedef struct packed {
    logic                  valid;
    logic [N_LOG2_MAX-1:0] addr_a;
    logic [N_LOG2_MAX-1:0] addr_b;
    logic                  bank;
  } pipe_entry_t;

endpackage

// File: rtl/fft_stage_sequencer_addr_gen.sv
// Radix-2 DIT in-place address generator: operand pair and twiddle index
// for butterfly k of stage s, purely combinational.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic [STG_W-1:0]  stage,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw_addr
);

  localparam int K_W = N_LOG2 - 1;

  logic [N_LOG2-1:0] span;
  logic [N_LOG2-1:0] hi;
  logic [K_W-1:0]    low;
  logic [K_W-1:0]    low_mask;
  logic [STG_W-1:0]  tw_sh;

  always_comb begin
    span     = N_LOG2'(1) << stage;
    low_mask = ~({K_W{1'b1}} << stage);
    low      = k & low_mask;
    // Upper k bits move up one position to open the gap for the B operand.
    hi       = ({1'b0, k} >> stage) << (stage + STG_W'(1));
    addr_a   = hi | {1'b0, low};
    addr_b   = addr_a + span;
    tw_sh    = STG_W'(N_LOG2 - 1) - stage;
    tw_addr  = low << tw_sh;
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place ping-pong radix-2 FFT.
// Optional issue stall via the FFT_SEQ_HOLD_EN macro (adds the hold port).
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2   = N_LOG2_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef FFT_SEQ_HOLD_EN
  input  logic              hold,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic              rd_bank,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
  output logic              wr_bank,
  output logic              result_bank
);

  localparam int K_W  = N_LOG2 - 1;
  localparam int DC_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [K_W-1:0]   K_LAST = '1;
  localparam logic [STG_W-1:0] S_LAST = STG_W'(N_LOG2 - 1);
  localparam logic [DC_W-1:0]  D_LAST = DC_W'(PIPE_LAT - 1);
  localparam logic             RES_BANK = 1'(N_LOG2 % 2);

  seq_state_e       state, state_nx;
  logic [STG_W-1:0] stage, stage_nx;
  logic [K_W-1:0]   k, k_nx;
  logic [DC_W-1:0]  dcnt, dcnt_nx;
  logic             rbank_nx;
  logic             issue_ok;
  logic             in_run;

  logic [N_LOG2-1:0] gen_a, gen_b;
  logic [N_LOG2-2:0] gen_tw;

  pipe_entry_t issue_p0;
  pipe_entry_t dly_p [PIPE_LAT];
  pipe_entry_t wr_head;

`ifdef FFT_SEQ_HOLD_EN
  assign issue_ok = ~hold;
`else
  assign issue_ok = 1'b1;
`endif

  fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .stage   (stage),
    .k       (k),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      stage       <= '0;
      k           <= '0;
      dcnt        <= '0;
      result_bank <= 1'b0;
    end else begin
      state       <= state_nx;
      stage       <= stage_nx;
      k           <= k_nx;
      dcnt        <= dcnt_nx;
      result_bank <= rbank_nx;
    end
  end

  always_comb begin
    state_nx = state;
    stage_nx = stage;
    k_nx     = k;
    dcnt_nx  = dcnt;
    rbank_nx = result_bank;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_RUN;
          stage_nx = '0;
          k_nx     = '0;
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        rd_en = issue_ok;
        if (issue_ok) begin
          k_nx = k + K_W'(1);
          if (k == K_LAST) begin
            state_nx = ST_DRAIN;
            dcnt_nx  = '0;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Hold off the next stage until the last write of this one has landed.
        if (dcnt == D_LAST) begin
          if (stage == S_LAST) begin
            state_nx = ST_FINISH;
            stage_nx = '0;
            rbank_nx = RES_BANK;
          end else begin
            state_nx = ST_RUN;
            stage_nx = stage + STG_W'(1);
          end
        end else begin
          dcnt_nx = dcnt + DC_W'(1);
        end
      end
      ST_FINISH: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign in_run    = (state == ST_RUN);
  assign rd_addr_a = in_run ? gen_a  : '0;
  assign rd_addr_b = in_run ? gen_b  : '0;
  assign tw_addr   = in_run ? gen_tw : '0;
  assign rd_bank   = stage[0];

  // Stage p0: issue entry entering the write-back delay line
  always_comb begin
    issue_p0        = '0;
    issue_p0.valid  = rd_en;
    issue_p0.addr_a = N_LOG2_MAX'(gen_a);
    issue_p0.addr_b = N_LOG2_MAX'(gen_b);
    issue_p0.bank   = stage[0];
  end

  // Only the valid bits are cleared; address payload just shifts through.
  always_ff @(posedge clk) begin
    dly_p[0] <= issue_p0;
    for (int i = 1; i < PIPE_LAT; i++) dly_p[i] <= dly_p[i-1];
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) dly_p[i].valid <= 1'b0;
    end
  end

  // Stage p(PIPE_LAT): butterfly result emerges, write back
  assign wr_head   = dly_p[PIPE_LAT-1];
  assign wr_en     = wr_head.valid;
  assign wr_addr_a = wr_head.valid ? wr_head.addr_a[N_LOG2-1:0] : '0;
  assign wr_addr_b = wr_head.valid ? wr_head.addr_b[N_LOG2-1:0] : '0;
  assign wr_bank   = wr_head.valid & ~wr_head.bank;

  generate
    if (N_LOG2 < N_LOG2_MAX) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^{wr_head.addr_a[N_LOG2_MAX-1:N_LOG2],
                           wr_head.addr_b[N_LOG2_MAX-1:N_LOG2]};
    end
  endgenerate

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N = 8 with a RAM/ROM/butterfly model.
module tb_fft_stage_sequencer;

  localparam int NL  = 3;
  localparam int N   = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
`ifdef FFT_SEQ_HOLD_EN
  logic          hold;
`endif
  logic          busy, done, rd_en, rd_bank, wr_en, wr_bank, result_bank;
  logic [NL-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [NL-2:0] tw_addr;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.N_LOG2(NL), .PIPE_LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef FFT_SEQ_HOLD_EN
    .hold        (hold),
`endif
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_bank     (rd_bank),
    .tw_addr     (tw_addr),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_addr_b   (wr_addr_b),
    .wr_bank     (wr_bank),
    .result_bank (result_bank)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
  int exp_bk [12] = '{0, 0, 0, 0,  1, 1, 1, 1,  0, 0, 0, 0};

  real mre [2][N];
  real mim [2][N];
  real romr [N/2];
  real romi [N/2];

  bit  h_v  [80];
  int  h_a  [80];
  int  h_b  [80];
  int  h_bk [80];
  real p_ar [80];
  real p_ai [80];
  real p_br [80];
  real p_bi [80];

  task automatic load(input int kind, input real amp);
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) begin
        mre[b][i] = 0.0;
        mim[b][i] = 0.0;
      end
    for (int i = 0; i < N; i++)
      mre[0][i] = (kind == 1 || i == 0) ? amp : 0.0;
  endtask

  task automatic check_out(input string nm, input int exp0, input int exp_rest);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_re%0d", nm, i), int'(mre[1][i] * 1000.0), (i == 0) ? exp0 : exp_rest);
      check($sformatf("%s_im%0d", nm, i), int'(mim[1][i] * 1000.0), 0);
    end
  endtask

  task automatic run_fft(input string nm, input int start_at, input int rst_at,
                         input int hold_at, input int exp_busy);
    int  cyc, busy_cnt, rd_cnt, wr_cnt, done_cnt, bk, ti, s;
    real tr, tim, ar, ai, br, bi;
    busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 80; i++) h_v[i] = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (cyc < 60) begin
      start = (cyc == start_at);
      rst   = (cyc == rst_at);
`ifdef FFT_SEQ_HOLD_EN
      hold  = (hold_at > 0 && cyc >= hold_at && cyc < hold_at + 3);
`endif
      @(negedge clk);
      if (cyc == 1) begin
        check({nm, "_first_busy"}, busy, 1);
        check({nm, "_first_rd"}, rd_en, 1);
        check({nm, "_done_clr"}, done, 0);
      end
      if (busy) busy_cnt++;
      if (hold_at > 0 && cyc >= hold_at && cyc < hold_at + 3)
        check({nm, "_hold_rd"}, rd_en, 0);
      if (wr_en) begin
        wr_cnt++;
        s = cyc - LAT;
        if (s >= 1 && h_v[s]) begin
          check({nm, "_wr_a"}, wr_addr_a, h_a[s]);
          check({nm, "_wr_b"}, wr_addr_b, h_b[s]);
          check({nm, "_wr_bank"}, wr_bank, 1 - h_bk[s]);
          bk = int'(wr_bank);
          mre[bk][wr_addr_a] = p_ar[s]; mim[bk][wr_addr_a] = p_ai[s];
          mre[bk][wr_addr_b] = p_br[s]; mim[bk][wr_addr_b] = p_bi[s];
        end else begin
          check({nm, "_wr_orphan"}, wr_en, 0);
        end
        if (rd_en) check({nm, "_wr_rd_bank"}, wr_bank, !rd_bank);
      end
      if (rd_en) begin
        if (rd_cnt < 12) begin
          check({nm, "_rd_a"}, rd_addr_a, exp_a[rd_cnt]);
          check({nm, "_rd_b"}, rd_addr_b, exp_b[rd_cnt]);
          check({nm, "_tw"}, tw_addr, exp_tw[rd_cnt]);
          check({nm, "_rd_bank"}, rd_bank, exp_bk[rd_cnt]);
        end
        bk = int'(rd_bank); ti = int'(tw_addr);
        ar = mre[bk][rd_addr_a]; ai = mim[bk][rd_addr_a];
        br = mre[bk][rd_addr_b]; bi = mim[bk][rd_addr_b];
        tr  = br * romr[ti] - bi * romi[ti];
        tim = br * romi[ti] + bi * romr[ti];
        p_ar[cyc] = ar - tr; p_ai[cyc] = ai - tim;
        p_br[cyc] = ar + tr; p_bi[cyc] = ai + tim;
        h_v[cyc] = 1'b1; h_a[cyc] = int'(rd_addr_a);
        h_b[cyc] = int'(rd_addr_b); h_bk[cyc] = int'(rd_bank);
        rd_cnt++;
      end
      if (rst_at > 0 && cyc > rst_at) begin
        check({nm, "_rst_busy"}, busy, 0);
        check({nm, "_rst_wr"}, wr_en, 0);
        check({nm, "_rst_rd"}, rd_en, 0);
        check({nm, "_rst_done"}, done, 0);
      end
      if (done) begin
        done_cnt++;
        check({nm, "_done_busy"}, busy, 0);
        check({nm, "_result_bank"}, result_bank, 1);
        break;
      end
      if (rst_at > 0 && cyc >= rst_at + 5) break;
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b0; start = 1'b0;
`ifdef FFT_SEQ_HOLD_EN
    hold = 1'b0;
`endif
    if (rst_at == 0) begin
      check({nm, "_busy_cycles"}, busy_cnt, exp_busy);
      check({nm, "_rd_count"}, rd_cnt, 12);
      check({nm, "_wr_count"}, wr_cnt, 12);
      check({nm, "_done_count"}, done_cnt, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < N/2; i++) begin
      romr[i] = -$cos(2.0 * 3.14159265358979 * i / N);
      romi[i] =  $sin(2.0 * 3.14159265358979 * i / N);
    end
    rst = 1'b1; start = 1'b0;
`ifdef FFT_SEQ_HOLD_EN
    hold = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_a", rd_addr_a, 0);
    check("rst_rd_b", rd_addr_b, 0);
    check("rst_tw", tw_addr, 0);
    check("rst_wr_a", wr_addr_a, 0);
    check("rst_wr_b", wr_addr_b, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_result_bank", result_bank, 0);
    @(posedge clk); #1 rst = 1'b0;

    load(0, 5.0);
    run_fft("imp", 0, 0, 0, 18);
    check_out("imp", 5000, 5000);

    load(1, 1.0);
    run_fft("dc", 0, 0, 0, 18);
    check_out("dc", 8000, 0);

    load(1, 1.0);
    run_fft("start_in_run", 5, 0, 0, 18);
    check_out("start_in_run", 8000, 0);

    load(0, 5.0);
    run_fft("mid_rst", 0, 9, 0, 0);

    load(0, 5.0);
    run_fft("post_rst", 0, 0, 0, 18);
    check_out("post_rst", 5000, 5000);

`ifdef FFT_SEQ_HOLD_EN
    load(1, 1.0);
    run_fft("hold", 0, 0, 3, 21);
    check_out("hold", 8000, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
